decode_stage: RTL
=================

// Module: decode_stage
// PURPOSE
// Registered, parametrised instruction-decode pipeline stage between fetch and execute.
// - Holds the reg/imm addressing-mode flag internally and toggles it on mode-switch opcodes.
// - Splits each instruction into opcode, two register fields and a LUT-expanded immediate.
// - Hands the result downstream over valid/ready.
// - A 2-entry skid buffer keeps one instruction per cycle while execute back-pressures.
// PARAMETERS
// INSTR_W   9   instruction word width
// OP_W      5   full opcode width (reg-reg mode opcode field)
// REG_W     3   register-index width on output (imm-mode field width)
// IMM_W     8   immediate width
// MODE_OP   0   opcode value that toggles mode
// PORTS
// clk         in   1        clock, all state on posedge
// rst_n       in   1        async active-low reset
// flush       in   1        drop all buffered instructions (taken branch); mode kept
// in_valid    in   1        fetch presents in_instr
// in_ready    out  1        stage can accept this cycle
// in_instr    in   INSTR_W  raw machine code
// out_valid   out  1        decoded instruction available
// out_ready   in   1        execute consumes this cycle
// out_opcode  out  OP_W     decoded opcode, zero-extended in imm mode
// out_reg1    out  REG_W    first register index
// out_reg2    out  REG_W    second register index / imm selector
// out_imm     out  IMM_W    expanded immediate, 0 in reg-reg mode
// out_mode    out  1        mode in force after this instruction (1 = imm)
// mode_q      out  1        current architectural mode register
// BEHAVIOUR
// - Reset (async, rst_n low): every output 0; mode_q=0 (reg-reg); both buffer entries invalid.
//   in_ready=1 from the first cycle after release.
// - Accept = in_valid & in_ready & !flush.
//   Decode uses mode_q at accept time.
//   Latency: accepted instruction appears on out_* the next cycle.
// - Reg-reg decode (mode_q=0), RR_W=(INSTR_W-OP_W)/2:
//   - opcode = instr[INSTR_W-1 -: OP_W]
//   - reg1 = zext(instr[2*RR_W-1 -: RR_W])
//   - reg2 = zext(instr[RR_W-1:0])
//   - imm = 0
// - Imm decode (mode_q=1), IOP_W=INSTR_W-2*REG_W:
//   - opcode = zext(instr[INSTR_W-1 -: IOP_W])
//   - reg1 = instr[2*REG_W-1 -: REG_W]
//   - reg2 = instr[REG_W-1:0]
//   - imm = IMM_LUT[reg2]
// - Mode switch: accepted opcode==MODE_OP in either mode.
//   - mode_q flips at that posedge.
//   - Instruction still forwarded, with out_mode = new mode.
//   - Back-to-back accepts see the updated mode.
// - Other instructions: out_mode = mode_q at decode.
// - Skid buffer: main reg drives out_*; skid reg holds one overflow entry.
//   - in_ready = !skid_valid (registered, no comb path from out_ready).
//   - Accept while main full and !out_ready: entry goes to skid.
//   - On drain, skid moves to main before any new input.
//   - Order strictly preserved.
// - out_* stable while out_valid & !out_ready.
// - flush: both entries invalid next cycle.
//   - Input that cycle is dropped; mode_q is not toggled by it.
//   - Mode changes from already-accepted instructions persist.
// - flush & out_ready same cycle: flush wins; nothing counts as consumed downstream.
// - rst_n asserted mid-operation: immediate return to reset state, no partial output.
// STRUCTURE
// - Package decode_pkg:
//   - IMM_LUT table {0,1,4,8,16,32,64,127}, sized 2**REG_W entries x IMM_W bits.
//   - decoded_t struct {opcode, reg1, reg2, imm, mode}.
//   - MODE_OP constant.
// - Sub-module field_decode: combinational instr+mode -> decoded_t.
//   Instantiated once; stage owns mode_q and the skid buffer.
// TESTING
// 1 Reset: rst_n low mid-stream -> all out_* 0, mode_q 0; in_ready 1 a cycle after release.
// 2 Reg mode: in_instr=9'b10110_01_11, out_ready=1 -> next cycle opcode 5'b10110, reg1 1, reg2 3, imm 0, out_mode 0.
// 3 Mode switch: 9'b00000_00_00 then 9'b011_010_110 -> first out_mode 1, mode_q 1;
//   second opcode 5'b00011, reg1 2, reg2 6, imm 64.
// 4 Back-pressure: out_ready=0, 3 valid instrs -> 2 accepted, in_ready 0;
//   out_ready=1 -> in-order drain, one per cycle, no loss or duplicate.
// 5 Flush: flush with 2 buffered plus in_valid -> out_valid 0 next cycle;
//   mode_q unchanged by the dropped instr, even if it is a mode switch.
// 6 Imm LUT sweep: imm mode, reg2 0..7 -> imm 0,1,4,8,16,32,64,127.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared widths, decoded-instruction record and immediate-expansion table
// for the fetch-to-execute decode stage.
package decode_pkg;

    localparam int INSTR_W = 9;
    localparam int OP_W    = 5;
    localparam int REG_W   = 3;
    localparam int IMM_W   = 8;
    localparam int RR_W    = (INSTR_W - OP_W) / 2;
    localparam int IOP_W   = INSTR_W - 2 * REG_W;

    localparam logic [OP_W-1:0] MODE_OP = '0;

    // Element [i] is the expansion of selector value i.
    localparam logic [2**REG_W-1:0][IMM_W-1:0] IMM_LUT = {
        8'd127, 8'd64, 8'd32, 8'd16, 8'd8, 8'd4, 8'd1, 8'd0
    };

    typedef struct packed {
        logic [OP_W-1:0]  opcode;
        logic [REG_W-1:0] reg1;
        logic [REG_W-1:0] reg2;
        logic [IMM_W-1:0] imm;
        logic             mode;
    } decoded_t;

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
interface decode_stage_if;
    import decode_pkg::*;

    logic                flush;
    logic                in_valid;
    logic                in_ready;
    logic [INSTR_W-1:0]  in_instr;
    logic                out_valid;
    logic                out_ready;
    logic [OP_W-1:0]     out_opcode;
    logic [REG_W-1:0]    out_reg1;
    logic [REG_W-1:0]    out_reg2;
    logic [IMM_W-1:0]    out_imm;
    logic                out_mode;
    logic                mode_q;

    modport slave (
        input  flush, in_valid, in_instr, out_ready,
        output in_ready, out_valid, out_opcode, out_reg1, out_reg2,
               out_imm, out_mode, mode_q
    );

    modport master (
        output flush, in_valid, in_instr, out_ready,
        input  in_ready, out_valid, out_opcode, out_reg1, out_reg2,
               out_imm, out_mode, mode_q
    );
endinterface

// File: rtl/decode_stage_field_decode.sv
// Purely combinational split of a raw instruction word into decoded fields,
// including the mode that will be in force once this instruction retires.
module field_decode
    import decode_pkg::*;
(
    input  logic [INSTR_W-1:0] instr_i,
    input  logic               mode_i,
    output decoded_t           dec_o
);

    always_comb begin
        dec_o = '0;
        if (!mode_i) begin
            dec_o.opcode = instr_i[INSTR_W-1 -: OP_W];
            dec_o.reg1   = REG_W'(instr_i[2*RR_W-1 -: RR_W]);
            dec_o.reg2   = REG_W'(instr_i[RR_W-1:0]);
            dec_o.imm    = '0;
        end else begin
            dec_o.opcode = OP_W'(instr_i[INSTR_W-1 -: IOP_W]);
            dec_o.reg1   = instr_i[2*REG_W-1 -: REG_W];
            dec_o.reg2   = instr_i[REG_W-1:0];
            dec_o.imm    = IMM_LUT[instr_i[REG_W-1:0]];
        end
        dec_o.mode = mode_i ^ (dec_o.opcode == MODE_OP);
    end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: owns the addressing-mode register and a two-entry
// skid buffer so fetch can stream one instruction per cycle under back-pressure.
module decode_stage
    import decode_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    decode_stage_if.slave bus
);

    decoded_t dec;
    decoded_t main_q, main_d;
    decoded_t skid_q, skid_d;
    logic     main_valid_q, main_valid_d;
    logic     skid_valid_q, skid_valid_d;
    logic     mode_q, mode_d;
    logic     rdy_q, rdy_d;
    logic     accept;
    logic     consume;

    field_decode u_field_decode (
        .instr_i (bus.in_instr),
        .mode_i  (mode_q),
        .dec_o   (dec)
    );

    assign accept  = bus.in_valid & rdy_q & ~bus.flush;
    assign consume = main_valid_q & bus.out_ready & ~bus.flush;

    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        mode_d       = accept ? dec.mode : mode_q;
        if (bus.flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || consume) begin
            // A parked skid entry always refills main ahead of new input.
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_d       = dec;
                main_valid_d = 1'b1;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = dec;
            skid_valid_d = 1'b1;
        end
        rdy_d = ~skid_valid_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            mode_q       <= 1'b0;
            rdy_q        <= 1'b0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            mode_q       <= mode_d;
            rdy_q        <= rdy_d;
        end
    end

    assign bus.in_ready   = rdy_q;
    assign bus.out_valid  = main_valid_q;
    assign bus.out_opcode = main_q.opcode;
    assign bus.out_reg1   = main_q.reg1;
    assign bus.out_reg2   = main_q.reg2;
    assign bus.out_imm    = main_q.imm;
    assign bus.out_mode   = main_q.mode;
    assign bus.mode_q     = mode_q;

endmodule
